suma_ctrl: RTL and testbench
============================

// Module: suma_ctrl
// PURPOSE
//  Sequencer for the keypad BCD adder datapath. Collects decimal digits per operand, stores operand A on
//  guardar, launches the external BCD adder after operand B, then latches and holds the sum for display.
//  Sits between the debounced keypad (push/entrada/guardar/finalizar) and the adder/display path.
// PARAMETERS
//  NDIG  3   digits per operand; operand width = 4*NDIG bits, result width = 4*(NDIG+1) bits
// PORTS
//  clk         in   1          system clock, all logic on rising edge
//  rst_n       in   1          asynchronous, active-low reset
//  push        in   1          keypad strobe, level from debouncer; may stay high >1 cycle
//  entrada     in   4          key code sampled on push rising edge; 0..9 digit, 10..15 ignored
//  guardar     in   1          store current operand; level, acted on rising edge
//  finalizar   in   1          synchronous clear to fresh entry; level, acted while high
//  sum_valid   in   1          adder result ready, 1-cycle pulse
//  sum_result  in   4*NDIG+4   BCD sum from adder, valid with sum_valid
//  numero      out  4*NDIG     operand being typed (BCD, LS digit in [3:0])
//  numero_sv   out  4*NDIG     stored operand A
//  sum_a/sum_b out  4*NDIG     adder operands, stable from sum_start until sum_valid
//  sum_start   out  1          1-cycle adder launch pulse
//  resultado   out  4*NDIG+4   latched sum
//  ent         out  2          digits entered in current operand (0..NDIG)
//  estado      out  2          current FSM state (calc_pkg::estado_t)
// BEHAVIOUR
//  Reset: all outputs 0, estado=S_OP_A. Reset mid-operation aborts everything, same values.
//  push and guardar: internal rising-edge detection, 1 action per edge. Action lands 1 cycle after edge sampled.
//  Digit entry (S_OP_A, S_OP_B): valid key with ent<NDIG -> numero={numero[4*NDIG-5:0],entrada}, ent+1.
//   ent==NDIG: digit dropped, numero unchanged. entrada>9: dropped.
//  S_OP_A + guardar: numero_sv<=numero, numero<=0, ent<=0 -> S_OP_B. ent==0 stores 0 (legal).
//  S_OP_B + guardar: sum_a<=numero_sv, sum_b<=numero, sum_start=1 for 1 cycle -> S_WAIT.
//  S_WAIT: push/guardar edges ignored. sum_valid -> resultado<=sum_result -> S_SHOW.
//   No timeout. sum_valid outside S_WAIT is ignored.
//  S_SHOW: resultado held. Valid digit push -> numero/numero_sv/resultado cleared, digit loaded as first digit
//   of A, ent=1 -> S_OP_A. guardar ignored.
//  Same-cycle push and guardar edges: guardar wins, digit discarded.
//  finalizar high, any state (incl. S_WAIT): has priority over all; next edge numero, numero_sv, resultado,
//   sum_a, sum_b, ent=0 -> S_OP_A. A sum_valid in that cycle is discarded.
//  Transitions: S_OP_A->S_OP_B->S_WAIT->S_SHOW->S_OP_A; finalizar returns to S_OP_A from any state.
// CONFIGURATION
//  BACKSPACE_EN defined: entrada==4'hB on push edge in S_OP_A/S_OP_B deletes last digit
//   (numero>>4, ent-1; no-op when ent==0).
//  BACKSPACE_EN undefined: 4'hB ignored like any other non-digit code.
// STRUCTURE
//  Package calc_pkg: estado_t enum {S_OP_A,S_OP_B,S_WAIT,S_SHOW}, BCD_MAX=4'd9, KEY_BORRAR=4'hB.
//  Sub-module flanco_det: 2-flop rising-edge pulse generator, instanced for push and guardar.
//  FSM and operand registers stay in suma_ctrl.
// TESTING
//  1 Push 3,5,7, guardar, push 4,2,1, guardar, adder model returns 0x0778 after 3 cycles
//    -> numero_sv=0x357, sum_start 1 pulse, sum_a=0x357, sum_b=0x421, resultado=0x0778, estado=S_SHOW.
//  2 Push held high 4 cycles with entrada=5 -> exactly one digit, numero=0x005, ent=1.
//  3 Push 1,2,3,4 in S_OP_A -> numero=0x123, 4 dropped. entrada=12 -> ignored.
//  4 push and guardar edges same cycle with numero=0x012 -> numero_sv=0x012, digit lost, S_OP_B.
//  5 finalizar during S_WAIT, then sum_valid -> all cleared, S_OP_A, resultado stays 0.
//    rst_n low mid-entry -> all outputs 0.
//  6 BACKSPACE_EN: push 9,8,key 0xB -> numero=0x009, ent=1. Without macro -> numero=0x098.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and constants for the keypad BCD adder sequencer.
//   estado_t   : sequencer states, encoded on the 2-bit estado port
//   BCD_MAX    : largest key code accepted as a decimal digit
//   KEY_BORRAR : key code used as backspace when BACKSPACE_EN is defined
package calc_pkg;

   typedef enum logic [1:0] {
      S_OP_A = 2'd0,
      S_OP_B = 2'd1,
      S_WAIT = 2'd2,
      S_SHOW = 2'd3
   } estado_t;

   localparam logic [3:0] BCD_MAX    = 4'd9;
   localparam logic [3:0] KEY_BORRAR = 4'hB;

   // True when the key code is a decimal digit 0..9.
   function automatic logic es_digito(input logic [3:0] key);
      return (key <= BCD_MAX);
   endfunction

endpackage

// File: rtl/flanco_det.sv
// Rising-edge detector for a debounced level input.
// Two flops: one holds the previous level, the other registers a one-cycle
// pulse for each low-to-high transition, so a level held high for many
// cycles yields exactly one pulse.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   sig_i      : level input
//   rise_o     : registered one-cycle pulse on each rising edge of sig_i
module flanco_det (
   input  logic clk,
   input  logic rst_n,
   input  logic sig_i,
   output logic rise_o
);

   logic prev_q;
   logic rise_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         prev_q <= sig_i;
         rise_q <= sig_i & ~prev_q;
      end
   end

   assign rise_o = rise_q;

endmodule

// File: rtl/suma_ctrl.sv
// Sequencer for the keypad BCD adder datapath.
// Collects decimal digits for operand A, stores it on guardar, collects
// operand B, launches the external adder on the second guardar, then
// latches and holds the sum until a new digit starts a fresh entry.
// Optional feature: define BACKSPACE_EN to make key 4'hB delete the last digit.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   push, entrada   : keypad strobe (level) and key code
//   guardar         : store-operand key (level)
//   finalizar       : synchronous clear to fresh entry (level)
//   sum_valid       : adder result strobe, sum_result its BCD value
//   numero          : operand being typed, numero_sv : stored operand A
//   sum_a, sum_b    : adder operands, sum_start : one-cycle adder launch
//   resultado       : latched sum, ent : digits typed, estado : FSM state
module suma_ctrl
   import calc_pkg::*;
#(
   parameter int unsigned NDIG = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic [3:0]            entrada,
   input  logic                  guardar,
   input  logic                  finalizar,
   input  logic                  sum_valid,
   input  logic [4*NDIG+3:0]     sum_result,
   output logic [4*NDIG-1:0]     numero,
   output logic [4*NDIG-1:0]     numero_sv,
   output logic [4*NDIG-1:0]     sum_a,
   output logic [4*NDIG-1:0]     sum_b,
   output logic                  sum_start,
   output logic [4*NDIG+3:0]     resultado,
   output logic [1:0]            ent,
   output logic [1:0]            estado
);

   localparam int unsigned OP_W  = 4 * NDIG;
   localparam int unsigned RES_W = 4 * NDIG + 4;
   localparam int unsigned ENT_W = 2;

   logic push_rise;
   logic guardar_rise;

   // Key code captured alongside the push edge so the action uses the
   // value present when the edge was sampled.
   logic [3:0] key_q;

   estado_t             estado_q,    estado_d;
   logic [OP_W-1:0]     numero_q,    numero_d;
   logic [OP_W-1:0]     numero_sv_q, numero_sv_d;
   logic [OP_W-1:0]     sum_a_q,     sum_a_d;
   logic [OP_W-1:0]     sum_b_q,     sum_b_d;
   logic                sum_start_q, sum_start_d;
   logic [RES_W-1:0]    resultado_q, resultado_d;
   logic [ENT_W-1:0]    ent_q,       ent_d;

   flanco_det u_push_edge (
      .clk    (clk),
      .rst_n  (rst_n),
      .sig_i  (push),
      .rise_o (push_rise)
   );

   flanco_det u_guardar_edge (
      .clk    (clk),
      .rst_n  (rst_n),
      .sig_i  (guardar),
      .rise_o (guardar_rise)
   );

   // Key code sample register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) key_q <= 4'd0;
      else        key_q <= entrada;
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado_q    <= S_OP_A;
         numero_q    <= '0;
         numero_sv_q <= '0;
         sum_a_q     <= '0;
         sum_b_q     <= '0;
         sum_start_q <= 1'b0;
         resultado_q <= '0;
         ent_q       <= '0;
      end else begin
         estado_q    <= estado_d;
         numero_q    <= numero_d;
         numero_sv_q <= numero_sv_d;
         sum_a_q     <= sum_a_d;
         sum_b_q     <= sum_b_d;
         sum_start_q <= sum_start_d;
         resultado_q <= resultado_d;
         ent_q       <= ent_d;
      end
   end

   // Next-state and datapath update; finalizar overrides everything.
   always_comb begin
      estado_d    = estado_q;
      numero_d    = numero_q;
      numero_sv_d = numero_sv_q;
      sum_a_d     = sum_a_q;
      sum_b_d     = sum_b_q;
      sum_start_d = 1'b0;
      resultado_d = resultado_q;
      ent_d       = ent_q;

      if (finalizar) begin
         estado_d    = S_OP_A;
         numero_d    = '0;
         numero_sv_d = '0;
         sum_a_d     = '0;
         sum_b_d     = '0;
         resultado_d = '0;
         ent_d       = '0;
      end else begin
         unique case (estado_q)
            S_OP_A, S_OP_B: begin
               // guardar beats a same-cycle digit, which is discarded.
               if (guardar_rise) begin
                  if (estado_q == S_OP_A) begin
                     numero_sv_d = numero_q;
                     numero_d    = '0;
                     ent_d       = '0;
                     estado_d    = S_OP_B;
                  end else begin
                     sum_a_d     = numero_sv_q;
                     sum_b_d     = numero_q;
                     sum_start_d = 1'b1;
                     estado_d    = S_WAIT;
                  end
               end else if (push_rise) begin
                  if (es_digito(key_q)) begin
                     if (ent_q < ENT_W'(NDIG)) begin
                        numero_d = {numero_q[OP_W-5:0], key_q};
                        ent_d    = ent_q + ENT_W'(1);
                     end
`ifdef BACKSPACE_EN
                  end else if (key_q == KEY_BORRAR) begin
                     if (ent_q != '0) begin
                        numero_d = numero_q >> 4;
                        ent_d    = ent_q - ENT_W'(1);
                     end
`endif
                  end
               end
            end
            S_WAIT: begin
               if (sum_valid) begin
                  resultado_d = sum_result;
                  estado_d    = S_SHOW;
               end
            end
            S_SHOW: begin
               // A new digit starts a fresh operand A with that digit.
               if (push_rise && es_digito(key_q)) begin
                  numero_d    = {(OP_W-4)'(0), key_q};
                  numero_sv_d = '0;
                  resultado_d = '0;
                  ent_d       = ENT_W'(1);
                  estado_d    = S_OP_A;
               end
            end
            default: estado_d = S_OP_A;
         endcase
      end
   end

   assign numero    = numero_q;
   assign numero_sv = numero_sv_q;
   assign sum_a     = sum_a_q;
   assign sum_b     = sum_b_q;
   assign sum_start = sum_start_q;
   assign resultado = resultado_q;
   assign ent       = ent_q;
   assign estado    = 2'(estado_q);

endmodule

// File: tb/tb_suma_ctrl.sv
// Directed self-checking bench for suma_ctrl (NDIG = 3).
module tb_suma_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        push;
   logic [3:0]  entrada;
   logic        guardar;
   logic        finalizar;
   logic        sum_valid;
   logic [15:0] sum_result;
   logic [11:0] numero;
   logic [11:0] numero_sv;
   logic [11:0] sum_a;
   logic [11:0] sum_b;
   logic        sum_start;
   logic [15:0] resultado;
   logic [1:0]  ent;
   logic [1:0]  estado;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   suma_ctrl #(.NDIG(3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push),
      .entrada    (entrada),
      .guardar    (guardar),
      .finalizar  (finalizar),
      .sum_valid  (sum_valid),
      .sum_result (sum_result),
      .numero     (numero),
      .numero_sv  (numero_sv),
      .sum_a      (sum_a),
      .sum_b      (sum_b),
      .sum_start  (sum_start),
      .resultado  (resultado),
      .ent        (ent),
      .estado     (estado)
   );

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press(input logic [3:0] d);
      entrada = d;
      push    = 1'b1;
      step(1);
      push    = 1'b0;
      step(2);
   endtask

   task automatic guard();
      guardar = 1'b1;
      step(1);
      guardar = 1'b0;
      step(2);
   endtask

   task automatic clear();
      finalizar = 1'b1;
      step(1);
      finalizar = 1'b0;
      step(1);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step(2);
      checks++; if (numero !== 12'h000 || numero_sv !== 12'h000) begin errors++;
         $display("FAIL reset_operands got numero=%h numero_sv=%h exp 000/000", numero, numero_sv); end
      checks++; if (sum_a !== 12'h000 || sum_b !== 12'h000 || sum_start !== 1'b0) begin errors++;
         $display("FAIL reset_adder got a=%h b=%h start=%b exp 000/000/0", sum_a, sum_b, sum_start); end
      checks++; if (resultado !== 16'h0000 || ent !== 2'd0 || estado !== 2'd0) begin errors++;
         $display("FAIL reset_state got res=%h ent=%0d estado=%0d exp 0000/0/0", resultado, ent, estado); end
      #3 rst_n = 1'b1;
      step(1);
   endtask

   task automatic test_full_sum();
      int cnt;
      logic [11:0] cap_a;
      logic [11:0] cap_b;
      cnt = 0; cap_a = '0; cap_b = '0;
      clear();
      press(4'd3); press(4'd5); press(4'd7);
      checks++; if (numero !== 12'h357 || ent !== 2'd3) begin errors++;
         $display("FAIL sum_entry_a got numero=%h ent=%0d exp 357/3", numero, ent); end
      guard();
      checks++; if (numero_sv !== 12'h357 || numero !== 12'h000 || estado !== 2'd1) begin errors++;
         $display("FAIL sum_store_a got sv=%h numero=%h estado=%0d exp 357/000/1", numero_sv, numero, estado); end
      press(4'd4); press(4'd2); press(4'd1);
      guardar = 1'b1;
      step(1);
      guardar = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step(1);
         if (sum_start === 1'b1) begin
            cnt++;
            cap_a = sum_a;
            cap_b = sum_b;
         end
      end
      checks++; if (cnt != 1) begin errors++;
         $display("FAIL sum_start_pulses got %0d exp 1", cnt); end
      checks++; if (cap_a !== 12'h357 || cap_b !== 12'h421) begin errors++;
         $display("FAIL sum_operands got a=%h b=%h exp 357/421", cap_a, cap_b); end
      checks++; if (estado !== 2'd2) begin errors++;
         $display("FAIL sum_wait_state got %0d exp 2", estado); end
      press(4'd9);
      checks++; if (numero !== 12'h421 || estado !== 2'd2) begin errors++;
         $display("FAIL wait_ignores_push got numero=%h estado=%0d exp 421/2", numero, estado); end
      sum_result = 16'h0778;
      sum_valid  = 1'b1;
      step(1);
      sum_valid  = 1'b0;
      sum_result = 16'h0000;
      step(1);
      checks++; if (resultado !== 16'h0778 || estado !== 2'd3) begin errors++;
         $display("FAIL sum_result got res=%h estado=%0d exp 0778/3", resultado, estado); end
      checks++; if (sum_a !== 12'h357 || sum_b !== 12'h421) begin errors++;
         $display("FAIL sum_operands_held got a=%h b=%h exp 357/421", sum_a, sum_b); end
      guard();
      checks++; if (estado !== 2'd3 || resultado !== 16'h0778) begin errors++;
         $display("FAIL show_ignores_guardar got estado=%0d res=%h exp 3/0778", estado, resultado); end
      press(4'd6);
      checks++; if (numero !== 12'h006 || ent !== 2'd1 || estado !== 2'd0) begin errors++;
         $display("FAIL show_new_digit got numero=%h ent=%0d estado=%0d exp 006/1/0", numero, ent, estado); end
      checks++; if (numero_sv !== 12'h000 || resultado !== 16'h0000) begin errors++;
         $display("FAIL show_clear got sv=%h res=%h exp 000/0000", numero_sv, resultado); end
   endtask

   task automatic test_push_held();
      clear();
      entrada = 4'd5;
      push    = 1'b1;
      step(4);
      push    = 1'b0;
      step(2);
      checks++; if (numero !== 12'h005 || ent !== 2'd1) begin errors++;
         $display("FAIL push_held got numero=%h ent=%0d exp 005/1", numero, ent); end
   endtask

   task automatic test_overflow_invalid();
      clear();
      press(4'd1); press(4'd2); press(4'd3); press(4'd4);
      checks++; if (numero !== 12'h123 || ent !== 2'd3) begin errors++;
         $display("FAIL overflow_drop got numero=%h ent=%0d exp 123/3", numero, ent); end
      clear();
      press(4'd7); press(4'd12);
      checks++; if (numero !== 12'h007 || ent !== 2'd1) begin errors++;
         $display("FAIL invalid_key got numero=%h ent=%0d exp 007/1", numero, ent); end
   endtask

   task automatic test_same_cycle();
      clear();
      press(4'd1); press(4'd2);
      entrada = 4'd7;
      push    = 1'b1;
      guardar = 1'b1;
      step(1);
      push    = 1'b0;
      guardar = 1'b0;
      step(2);
      checks++; if (numero_sv !== 12'h012 || numero !== 12'h000 || ent !== 2'd0 || estado !== 2'd1) begin errors++;
         $display("FAIL same_cycle got sv=%h numero=%h ent=%0d estado=%0d exp 012/000/0/1", numero_sv, numero, ent, estado); end
   endtask

   task automatic test_finalizar_reset();
      // still in S_OP_B from the previous scenario
      press(4'd3);
      guard();
      checks++; if (estado !== 2'd2) begin errors++;
         $display("FAIL fin_reach_wait got %0d exp 2", estado); end
      finalizar  = 1'b1;
      sum_valid  = 1'b1;
      sum_result = 16'h0999;
      step(1);
      finalizar  = 1'b0;
      step(1);
      sum_valid  = 1'b0;
      sum_result = 16'h0000;
      step(1);
      checks++; if (estado !== 2'd0 || resultado !== 16'h0000 || ent !== 2'd0) begin errors++;
         $display("FAIL fin_state got estado=%0d res=%h ent=%0d exp 0/0000/0", estado, resultado, ent); end
      checks++; if (numero !== 12'h000 || numero_sv !== 12'h000 || sum_a !== 12'h000 || sum_b !== 12'h000) begin errors++;
         $display("FAIL fin_regs got n=%h sv=%h a=%h b=%h exp all 000", numero, numero_sv, sum_a, sum_b); end
      press(4'd4); press(4'd5);
      #2 rst_n = 1'b0;
      #1;
      checks++; if (numero !== 12'h000 || ent !== 2'd0 || estado !== 2'd0 || sum_start !== 1'b0) begin errors++;
         $display("FAIL mid_reset got numero=%h ent=%0d estado=%0d start=%b exp 000/0/0/0", numero, ent, estado, sum_start); end
      step(1);
      #3 rst_n = 1'b1;
      step(1);
   endtask

   task automatic test_backspace();
      logic [11:0] exp_n;
      logic [1:0]  exp_e;
`ifdef BACKSPACE_EN
      exp_n = 12'h009; exp_e = 2'd1;
`else
      exp_n = 12'h098; exp_e = 2'd2;
`endif
      clear();
      press(4'd9); press(4'd8); press(4'hB);
      checks++; if (numero !== exp_n || ent !== exp_e) begin errors++;
         $display("FAIL backspace got numero=%h ent=%0d exp %h/%0d", numero, ent, exp_n, exp_e); end
   endtask

   initial begin
      rst_n = 1'b0; push = 1'b0; entrada = 4'd0; guardar = 1'b0;
      finalizar = 1'b0; sum_valid = 1'b0; sum_result = 16'h0000;
      test_reset();
      test_full_sum();
      test_push_held();
      test_overflow_invalid();
      test_same_cycle();
      test_finalizar_reset();
      test_backspace();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
